rx_frame_buf_ctrl: RTL and testbench

Two-bank (ping-pong) frame buffer controller between the GMII UDP receiver and the consumer that reads UDP payloads. It takes the receiver's 32-bit payload word stream and writes each frame into one bank of a shared single-port RAM, then presents completed frames in arrival order. It also arbitrates the single RAM port between receiver writes, which always win, and consumer reads. When no bank is free, or a frame overruns its bank, the whole frame is dropped.

---
 rtl/rx_frame_buf_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rx_frame_buf_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_buf_ctrl.sv
// Ping-pong frame buffer controller: writes receiver payload frames into two RAM banks, presents them in order.
// Optional dropped-frame counter output enabled by defining RXBUF_DROP_CNT_EN.
module rx_frame_buf_ctrl #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  input  logic          wr_last,
  input  logic          wr_abort,
  input  logic [15:0]   wr_len,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW:0]   ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_dvalid,
  output logic [31:0]   rd_data,
  output logic          frm_avail,
  output logic [15:0]   frm_len,
  output logic          frm_bank,
`ifdef RXBUF_DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  input  logic          frm_release
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY} bank_st_t;

  w_state_t    w_state, w_state_nxt;
  bank_st_t    bank_st [2];
  bank_st_t    bank_nxt [2];
  logic        wp, wp_nxt, rp, rp_nxt;
  logic [AW:0] count, count_nxt;
  logic        ovr, ovr_nxt;
  logic [15:0] len_q [2];
  logic        wr_en, commit;

  always_comb begin
    w_state_nxt = w_state;
    bank_nxt    = bank_st;
    wp_nxt      = wp;
    rp_nxt      = rp;
    count_nxt   = count;
    ovr_nxt     = ovr;
    wr_en       = 1'b0;
    commit      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (wr_valid) begin
          if (bank_st[wp] == B_FREE) begin
            wr_en = 1'b1;
            if (wr_last) begin
              commit       = 1'b1;
              bank_nxt[wp] = B_READY;
              wp_nxt       = ~wp;
            end else begin
              bank_nxt[wp] = B_FILL;
              count_nxt    = {{AW{1'b0}}, 1'b1};
              ovr_nxt      = 1'b0;
              w_state_nxt  = W_FILL;
            end
          end else if (!wr_last) begin
            w_state_nxt = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (wr_abort) begin
          bank_nxt[wp] = B_FREE;
          count_nxt    = '0;
          w_state_nxt  = W_IDLE;
        end else begin
          // count[AW] set means the bank is full; further words mark overrun
          if (wr_valid) begin
            if (!count[AW]) begin
              wr_en     = 1'b1;
              count_nxt = count + 1'b1;
            end else begin
              ovr_nxt = 1'b1;
            end
          end
          if (wr_last) begin
            if (ovr_nxt) begin
              bank_nxt[wp] = B_FREE;
            end else begin
              commit       = 1'b1;
              bank_nxt[wp] = B_READY;
              wp_nxt       = ~wp;
            end
            count_nxt   = '0;
            w_state_nxt = W_IDLE;
          end
        end
      end
      W_DROP: begin
        if (wr_abort || wr_last) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
    // a READY bank at rp can never be the bank the write side is touching
    if (frm_release && bank_st[rp] == B_READY) begin
      bank_nxt[rp] = B_FREE;
      rp_nxt       = ~rp;
    end
  end

  assign ram_we    = wr_en;
  assign rd_gnt    = rd_req & ~wr_en;
  assign ram_en    = wr_en | rd_gnt;
  assign ram_addr  = wr_en ? {wp, count[AW-1:0]} : {rp, rd_addr};
  assign ram_wdata = wr_data;
  assign rd_data   = ram_rdata;
  assign frm_avail = (bank_st[rp] == B_READY);
  assign frm_bank  = rp;
  assign frm_len   = len_q[rp];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      w_state    <= W_IDLE;
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      wp         <= 1'b0;
      rp         <= 1'b0;
      count      <= '0;
      ovr        <= 1'b0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      rd_dvalid  <= 1'b0;
    end else begin
      w_state   <= w_state_nxt;
      bank_st   <= bank_nxt;
      wp        <= wp_nxt;
      rp        <= rp_nxt;
      count     <= count_nxt;
      ovr       <= ovr_nxt;
      rd_dvalid <= rd_gnt;
      if (commit) len_q[wp] <= wr_len;
    end
  end

`ifdef RXBUF_DROP_CNT_EN
  logic drop_evt;

  // frame end seen while discarding: no free bank at start, or bank overrun
  assign drop_evt = wr_last &
    ((w_state == W_IDLE && wr_valid && bank_st[wp] != B_FREE) |
     (!wr_abort && ((w_state == W_FILL && (ovr || (wr_valid && count[AW]))) ||
                    w_state == W_DROP)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) drop_cnt <= '0;
    else if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rx_frame_buf_ctrl.sv
// Self-checking bench for rx_frame_buf_ctrl: write/read scoreboards, ping-pong order, drops, arbitration, clear.
module tb_rx_frame_buf_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  always #5 clk = ~clk;

  logic        wr_valid, wr_last, wr_abort, rd_req, frm_release;
  logic [31:0] wr_data, ram_wdata, ram_rdata, rd_data;
  logic [15:0] wr_len, frm_len, drop_cnt;
  logic        ram_en, ram_we, rd_gnt, rd_dvalid, frm_avail, frm_bank;
  logic [9:0]  ram_addr;
  logic [8:0]  rd_addr;

  logic        o_wr_valid, o_wr_last, o_wr_abort, o_rd_req, o_frm_release;
  logic [31:0] o_wr_data, o_ram_wdata, o_ram_rdata, o_rd_data;
  logic [15:0] o_wr_len, o_frm_len, o_drop_cnt;
  logic        o_ram_en, o_ram_we, o_rd_gnt, o_rd_dvalid, o_frm_avail, o_frm_bank;
  logic [2:0]  o_ram_addr;
  logic [1:0]  o_rd_addr;

  rx_frame_buf_ctrl #(.AW(9)) u_dut (
    .clk(clk), .clr(clr), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_abort(wr_abort), .wr_len(wr_len), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_dvalid(rd_dvalid),
    .rd_data(rd_data), .frm_avail(frm_avail), .frm_len(frm_len), .frm_bank(frm_bank),
`ifdef RXBUF_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .frm_release(frm_release)
  );

  rx_frame_buf_ctrl #(.AW(2)) u_dut_small (
    .clk(clk), .clr(clr), .wr_valid(o_wr_valid), .wr_data(o_wr_data), .wr_last(o_wr_last),
    .wr_abort(o_wr_abort), .wr_len(o_wr_len), .ram_en(o_ram_en), .ram_we(o_ram_we),
    .ram_addr(o_ram_addr), .ram_wdata(o_ram_wdata), .ram_rdata(o_ram_rdata),
    .rd_req(o_rd_req), .rd_addr(o_rd_addr), .rd_gnt(o_rd_gnt), .rd_dvalid(o_rd_dvalid),
    .rd_data(o_rd_data), .frm_avail(o_frm_avail), .frm_len(o_frm_len), .frm_bank(o_frm_bank),
`ifdef RXBUF_DROP_CNT_EN
    .drop_cnt(o_drop_cnt),
`endif
    .frm_release(o_frm_release)
  );

`ifndef RXBUF_DROP_CNT_EN
  assign drop_cnt   = 16'd0;
  assign o_drop_cnt = 16'd0;
`endif

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end
  assign o_ram_rdata = 32'd0;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [41:0] wq [$];
  logic [31:0] rq [$];
  logic [41:0] we_exp;
  logic [31:0] rd_exp;

  task automatic drv(input logic v, input logic [31:0] d, input logic l, input logic [15:0] ln);
    @(negedge clk);
    wr_valid = v; wr_data = d; wr_last = l; wr_len = ln; wr_abort = 1'b0; frm_release = 1'b0;
  endtask

  task automatic apply_clr();
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0; wr_abort = 1'b0; rd_req = 1'b0; frm_release = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({ram_en, ram_we, rd_gnt, rd_dvalid, frm_avail, frm_bank} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {ram_en, ram_we, rd_gnt, rd_dvalid, frm_avail, frm_bank});
    else pass_cnt++;
    total_cnt++;
    if (frm_len !== 16'd0 || drop_cnt !== 16'd0)
      $display("FAIL reset_len_drop: got len=%0d drop=%0d want 0 0", frm_len, drop_cnt);
    else pass_cnt++;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 8; i++) begin
      wq.push_back({10'(i), 32'h1000_0000 + 32'(i)});
      drv(1'b1, 32'h1000_0000 + 32'(i), (i == 7), 16'd40);
      #1;
      total_cnt++;
      if (ram_we === 1'b1 && wq.size() > 0) begin
        we_exp = wq.pop_front();
        if ({ram_addr, ram_wdata} !== we_exp)
          $display("FAIL single_wr%0d: got %h want %h", i, {ram_addr, ram_wdata}, we_exp);
        else pass_cnt++;
      end else $display("FAIL single_wr%0d: got ram_we=%b want 1", i, ram_we);
    end
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    #1;
    total_cnt++;
    if ({frm_avail, frm_bank, frm_len} !== {1'b1, 1'b0, 16'd40})
      $display("FAIL single_present: got avail=%b bank=%b len=%0d want 1 0 40", frm_avail, frm_bank, frm_len);
    else pass_cnt++;
    @(negedge clk); rd_req = 1'b1; rd_addr = 9'd3;
    #1;
    total_cnt++;
    if (rd_gnt !== 1'b1) $display("FAIL single_gnt: got %b want 1", rd_gnt);
    else begin pass_cnt++; rq.push_back(32'h1000_0003); end
    @(negedge clk); rd_req = 1'b0;
    total_cnt++;
    if (rd_dvalid !== 1'b1 || rq.size() == 0) $display("FAIL single_rd: got dvalid=%b want 1", rd_dvalid);
    else begin
      rd_exp = rq.pop_front();
      if (rd_data !== rd_exp) $display("FAIL single_rd: got %h want %h", rd_data, rd_exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        wq.push_back({10'(i), 32'hA000_0000 + 32'(i)});
        drv(1'b1, 32'hA000_0000 + 32'(i), (i == 3), 16'd100);
      end else begin
        wq.push_back({10'(512 + i - 4), 32'hB000_0000 + 32'(i - 4)});
        drv(1'b1, 32'hB000_0000 + 32'(i - 4), (i == 6), 16'd60);
      end
      #1;
      total_cnt++;
      if (ram_we === 1'b1 && wq.size() > 0) begin
        we_exp = wq.pop_front();
        if ({ram_addr, ram_wdata} !== we_exp)
          $display("FAIL b2b_wr%0d: got %h want %h", i, {ram_addr, ram_wdata}, we_exp);
        else pass_cnt++;
      end else $display("FAIL b2b_wr%0d: got ram_we=%b want 1", i, ram_we);
    end
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    #1;
    total_cnt++;
    if ({frm_avail, frm_bank, frm_len} !== {1'b1, 1'b0, 16'd100})
      $display("FAIL b2b_present_a: got avail=%b bank=%b len=%0d want 1 0 100", frm_avail, frm_bank, frm_len);
    else pass_cnt++;
  endtask

  task automatic test_drop_full();
    int bad;
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'hCC00_0000 + 32'(i), (i == 1), 16'd8);
      #1;
      total_cnt++;
      if (ram_we !== 1'b0) $display("FAIL full_nowr%0d: got ram_we=%b want 0", i, ram_we);
      else pass_cnt++;
    end
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    #1;
`ifdef RXBUF_DROP_CNT_EN
    total_cnt++;
    if (drop_cnt !== 16'd1) $display("FAIL full_drop_cnt: got %0d want 1", drop_cnt);
    else pass_cnt++;
`endif
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[i] !== 32'hA000_0000 + 32'(i)) bad++;
    for (int i = 0; i < 3; i++) if (mem[512 + i] !== 32'hB000_0000 + 32'(i)) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL full_contents: got %0d corrupted words want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_release_order();
    @(negedge clk); frm_release = 1'b1;
    @(negedge clk); frm_release = 1'b0;
    #1;
    total_cnt++;
    if ({frm_avail, frm_bank, frm_len} !== {1'b1, 1'b1, 16'd60})
      $display("FAIL rel_present_b: got avail=%b bank=%b len=%0d want 1 1 60", frm_avail, frm_bank, frm_len);
    else pass_cnt++;
    @(negedge clk); rd_req = 1'b1; rd_addr = 9'd1;
    #1;
    total_cnt++;
    if (rd_gnt !== 1'b1 || ram_addr !== 10'd513)
      $display("FAIL rel_gnt: got gnt=%b addr=%0d want 1 513", rd_gnt, ram_addr);
    else begin pass_cnt++; rq.push_back(32'hB000_0001); end
    @(negedge clk); rd_req = 1'b0;
    total_cnt++;
    if (rd_dvalid !== 1'b1 || rq.size() == 0) $display("FAIL rel_rd: got dvalid=%b want 1", rd_dvalid);
    else begin
      rd_exp = rq.pop_front();
      if (rd_data !== rd_exp) $display("FAIL rel_rd: got %h want %h", rd_data, rd_exp);
      else pass_cnt++;
    end
    @(negedge clk); frm_release = 1'b1;
    @(negedge clk); frm_release = 1'b0;
    #1;
    total_cnt++;
    if ({frm_avail, frm_bank} !== 2'b00) $display("FAIL rel_empty: got avail=%b bank=%b want 0 0", frm_avail, frm_bank);
    else pass_cnt++;
    // release with nothing presented must not move the read pointer
    @(negedge clk); frm_release = 1'b1;
    @(negedge clk); frm_release = 1'b0;
    #1;
    total_cnt++;
    if (frm_bank !== 1'b0) $display("FAIL rel_ignored: got bank=%b want 0", frm_bank);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o_wr_valid = 1'b1; o_wr_data = 32'hD000_0000 + 32'(i); o_wr_last = (i == 4); o_wr_len = 16'd20;
      #1;
      total_cnt++;
      if (i < 4) begin
        if ({o_ram_we, o_ram_addr, o_ram_wdata} !== {1'b1, 3'(i), 32'hD000_0000 + 32'(i)})
          $display("FAIL ovr_wr%0d: got we=%b addr=%0d data=%h want 1 %0d %h", i, o_ram_we, o_ram_addr, o_ram_wdata, i, 32'hD000_0000 + 32'(i));
        else pass_cnt++;
      end else begin
        if (o_ram_we !== 1'b0) $display("FAIL ovr_nowr: got we=%b want 0", o_ram_we);
        else pass_cnt++;
      end
    end
    @(negedge clk); o_wr_valid = 1'b0; o_wr_last = 1'b0;
    #1;
    total_cnt++;
    if (o_frm_avail !== 1'b0) $display("FAIL ovr_avail: got %b want 0", o_frm_avail);
    else pass_cnt++;
`ifdef RXBUF_DROP_CNT_EN
    total_cnt++;
    if (o_drop_cnt !== 16'd1) $display("FAIL ovr_drop_cnt: got %0d want 1", o_drop_cnt);
    else pass_cnt++;
`endif
    @(negedge clk);
    o_wr_valid = 1'b1; o_wr_data = 32'hE000_0001; o_wr_last = 1'b1; o_wr_len = 16'd4;
    #1;
    total_cnt++;
    if ({o_ram_we, o_ram_addr} !== {1'b1, 3'd0}) $display("FAIL ovr_refill: got we=%b addr=%0d want 1 0", o_ram_we, o_ram_addr);
    else pass_cnt++;
    @(negedge clk); o_wr_valid = 1'b0; o_wr_last = 1'b0;
    #1;
    total_cnt++;
    if ({o_frm_avail, o_frm_bank, o_frm_len} !== {1'b1, 1'b0, 16'd4})
      $display("FAIL ovr_single: got avail=%b bank=%b len=%0d want 1 0 4", o_frm_avail, o_frm_bank, o_frm_len);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 2; i++) drv(1'b1, 32'hC000_0000 + 32'(i), (i == 1), 16'd8);
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      wq.push_back({10'(512 + i), 32'hF000_0000 + 32'(i)});
      drv(1'b1, 32'hF000_0000 + 32'(i), (i == 2), 16'd12);
      rd_req = 1'b1; rd_addr = 9'd1;
      #1;
      total_cnt++;
      if (rd_gnt === 1'b0 && ram_we === 1'b1 && wq.size() > 0) begin
        we_exp = wq.pop_front();
        if ({ram_addr, ram_wdata} !== we_exp)
          $display("FAIL arb_wr%0d: got %h want %h", i, {ram_addr, ram_wdata}, we_exp);
        else pass_cnt++;
      end else $display("FAIL arb_block%0d: got gnt=%b we=%b want 0 1", i, rd_gnt, ram_we);
    end
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    #1;
    total_cnt++;
    if ({rd_gnt, ram_en, ram_we, ram_addr} !== {3'b110, 10'd1})
      $display("FAIL arb_gnt: got gnt=%b en=%b we=%b addr=%0d want 1 1 0 1", rd_gnt, ram_en, ram_we, ram_addr);
    else begin pass_cnt++; rq.push_back(32'hC000_0001); end
    @(negedge clk); rd_req = 1'b0;
    total_cnt++;
    if (rd_dvalid !== 1'b1 || rq.size() == 0) $display("FAIL arb_rd: got dvalid=%b want 1", rd_dvalid);
    else begin
      rd_exp = rq.pop_front();
      if (rd_data !== rd_exp) $display("FAIL arb_rd: got %h want %h", rd_data, rd_exp);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (rd_dvalid !== 1'b0) $display("FAIL arb_dvalid_pulse: got %b want 0", rd_dvalid);
    else pass_cnt++;
  endtask

  task automatic test_abort_clr();
    for (int i = 0; i < 2; i++) drv(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 16'd0);
    @(negedge clk); wr_valid = 1'b0; wr_abort = 1'b1;
    #1;
    total_cnt++;
    if (ram_we !== 1'b0) $display("FAIL abort_nowr: got we=%b want 0", ram_we);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      wq.push_back({10'(i), 32'h6000_0000 + 32'(i)});
      drv(1'b1, 32'h6000_0000 + 32'(i), (i == 2), 16'd12);
      #1;
      total_cnt++;
      if (ram_we === 1'b1 && wq.size() > 0) begin
        we_exp = wq.pop_front();
        if ({ram_addr, ram_wdata} !== we_exp)
          $display("FAIL abort_refill%0d: got %h want %h", i, {ram_addr, ram_wdata}, we_exp);
        else pass_cnt++;
      end else $display("FAIL abort_refill%0d: got ram_we=%b want 1", i, ram_we);
    end
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    #1;
    total_cnt++;
    if ({frm_avail, frm_len, drop_cnt} !== {1'b1, 16'd12, 16'd0})
      $display("FAIL abort_present: got avail=%b len=%0d drop=%0d want 1 12 0", frm_avail, frm_len, drop_cnt);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) drv(1'b1, 32'h7000_0000 + 32'(i), 1'b0, 16'd0);
    @(negedge clk);
    wr_valid = 1'b0; clr = 1'b1;
    #1;
    total_cnt++;
    if ({ram_en, ram_we, rd_gnt, rd_dvalid, frm_avail, frm_bank, frm_len} !== {6'b0, 16'd0})
      $display("FAIL clr_outputs: got en=%b we=%b gnt=%b dv=%b avail=%b bank=%b len=%0d want all 0",
               ram_en, ram_we, rd_gnt, rd_dvalid, frm_avail, frm_bank, frm_len);
    else pass_cnt++;
    #2 clr = 1'b0;
    wq.push_back({10'd0, 32'h8000_0001});
    drv(1'b1, 32'h8000_0001, 1'b1, 16'd4);
    #1;
    total_cnt++;
    if (ram_we === 1'b1 && wq.size() > 0) begin
      we_exp = wq.pop_front();
      if ({ram_addr, ram_wdata} !== we_exp) $display("FAIL clr_bank0: got %h want %h", {ram_addr, ram_wdata}, we_exp);
      else pass_cnt++;
    end else $display("FAIL clr_bank0: got ram_we=%b want 1", ram_we);
    drv(1'b0, 32'd0, 1'b0, 16'd0);
    #1;
    total_cnt++;
    if ({frm_avail, frm_bank, frm_len} !== {1'b1, 1'b0, 16'd4})
      $display("FAIL clr_present: got avail=%b bank=%b len=%0d want 1 0 4", frm_avail, frm_bank, frm_len);
    else pass_cnt++;
  endtask

  initial begin
    clr = 1'b1;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; wr_abort = 1'b0; wr_len = '0;
    rd_req = 1'b0; rd_addr = '0; frm_release = 1'b0;
    o_wr_valid = 1'b0; o_wr_data = '0; o_wr_last = 1'b0; o_wr_abort = 1'b0; o_wr_len = '0;
    o_rd_req = 1'b0; o_rd_addr = '0; o_frm_release = 1'b0;
    test_reset();
    test_single_frame();
    apply_clr();
    test_back_to_back();
    test_drop_full();
    test_release_order();
    test_overrun();
    apply_clr();
    test_arbitration();
    apply_clr();
    test_abort_clr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
